bank_port_arbiter: RTL and testbench

- Shares one single-port weight/clause SRAM bank between two requesters: the configuration write stream (SPI write words, already moved into the system clock domain) and the inference engine's read port.
- Reads have priority. Writes are buffered in a small FIFO.
- A starvation guard forces a write slot after a bounded wait.
- One instance sits in front of each shared bank, between the SPI write path and the PE-column read logic.

---
 rtl/bank_port_arbiter.sv | 167 ++++++++++++++++
 tb/tb_bank_port_arbiter.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bank_port_arbiter.sv
// bank_port_arbiter
//   Shares one single-port SRAM bank between the configuration write stream
//   and the inference-engine read port. Reads win by default. Writes wait in
//   a small FIFO, and a starvation guard forces one write slot after
//   MAX_WAIT consecutive denied cycles.
//
// Ports
//   clk, rst_n          system clock, asynchronous active-low reset
//   flush               discard every queued write (synchronous)
//   spi_wr_*            write request stream (valid/ready, addr, data)
//   rd_valid/rd_ready   read request; rd_ready high means the read is granted
//   rd_addr             read address
//   rd_data_valid       high one cycle after a read grant
//   rd_data             read data, straight from mem_rdata
//   mem_*               SRAM port (cen/wen active high, addr, wdata, rdata)
//   fifo_level          number of queued writes
//   force_active        debug: the forced write slot is taking place
module bank_port_arbiter #(
  parameter int AW         = 12,
  parameter int DW         = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int MAX_WAIT   = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          flush,
  input  logic                          spi_wr_valid,
  output logic                          spi_wr_ready,
  input  logic [AW-1:0]                 spi_wr_addr,
  input  logic [DW-1:0]                 spi_wr_data,
  input  logic                          rd_valid,
  output logic                          rd_ready,
  input  logic [AW-1:0]                 rd_addr,
  output logic                          rd_data_valid,
  output logic [DW-1:0]                 rd_data,
  output logic                          mem_cen,
  output logic                          mem_wen,
  output logic [AW-1:0]                 mem_addr,
  output logic [DW-1:0]                 mem_wdata,
  input  logic [DW-1:0]                 mem_rdata,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          force_active
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = PW + 1;

  typedef enum logic {ST_NORMAL, ST_FORCE} state_t;

  state_t        state_q, state_d;
  logic [7:0]    wait_q, wait_d;

  logic [AW-1:0] fifo_addr [FIFO_DEPTH];
  logic [DW-1:0] fifo_data [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [LW-1:0] level_q;

  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic          rd_data_valid_q;

  logic empty, full, push, pop, wr_grant, rd_grant;

  assign empty = (level_q == '0);
  assign full  = (level_q == LW'(FIFO_DEPTH));

  // Outputs are gated by rst_n so nothing is granted while reset is held,
  // even though the registers already sit at their reset values.
  assign spi_wr_ready = rst_n && !full;
  assign rd_ready     = rst_n && (state_q == ST_NORMAL);
  assign rd_grant     = rd_valid && rd_ready;
  assign wr_grant     = rst_n && !empty && (!rd_valid || state_q == ST_FORCE);

  // A push in the flush cycle is thrown away along with the queue.
  assign push = spi_wr_valid && spi_wr_ready && !flush;
  assign pop  = wr_grant;

  assign mem_cen   = rd_grant || wr_grant;
  assign mem_wen   = wr_grant;
  assign mem_addr  = rd_grant ? rd_addr :
                     wr_grant ? fifo_addr[rd_ptr_q] : addr_q;
  assign mem_wdata = wr_grant ? fifo_data[rd_ptr_q] : wdata_q;

  assign rd_data       = mem_rdata;
  assign rd_data_valid = rd_data_valid_q;
  assign fifo_level    = level_q;
  assign force_active  = (state_q == ST_FORCE);

  // NOTE: FIFO storage has no reset; the pointers and level define which
  // entries are meaningful, so clearing the array would only add muxes.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr[wr_ptr_q] <= spi_wr_addr;
      fifo_data[wr_ptr_q] <= spi_wr_data;
    end
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // in the design samples values from before the same clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      // DEPTH is a power of two, so pointer overflow is the wrap.
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      case ({push, pop})
        2'b10:   level_q <= level_q + LW'(1);
        2'b01:   level_q <= level_q - LW'(1);
        default: level_q <= level_q;
      endcase
    end
  end

  // NOTE: every signal written here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_d = ST_NORMAL;
    wait_d  = wait_q;
    case (state_q)
      ST_NORMAL: begin
        if (empty || wr_grant) begin
          wait_d = '0;
        end else if (wait_q == 8'(MAX_WAIT - 1)) begin
          wait_d = '0;
          // A flush empties the queue, so there is nothing to force.
          if (!flush) state_d = ST_FORCE;
        end else if (wait_q != 8'hFF) begin
          wait_d = wait_q + 8'd1;
        end
      end
      ST_FORCE: begin
        wait_d  = '0;
        state_d = ST_NORMAL;
      end
      default: begin
        wait_d  = '0;
        state_d = ST_NORMAL;
      end
    endcase
    if (flush) wait_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= ST_NORMAL;
      wait_q          <= '0;
      addr_q          <= '0;
      wdata_q         <= '0;
      rd_data_valid_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      wait_q          <= wait_d;
      rd_data_valid_q <= rd_grant;
      // Hold the last address/data on idle cycles to avoid toggling the SRAM pins.
      if (mem_cen)  addr_q  <= mem_addr;
      if (wr_grant) wdata_q <= mem_wdata;
    end
  end

endmodule

// File: tb/tb_bank_port_arbiter.sv
// tb_bank_port_arbiter
//   Directed bench for bank_port_arbiter with a behavioural single-port SRAM
//   (one-cycle read latency) and a log of every SRAM write.
module tb_bank_port_arbiter;

  localparam int AW = 12;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          flush = 1'b0;
  logic          spi_wr_valid = 1'b0;
  logic          spi_wr_ready;
  logic [AW-1:0] spi_wr_addr = '0;
  logic [DW-1:0] spi_wr_data = '0;
  logic          rd_valid = 1'b0;
  logic          rd_ready;
  logic [AW-1:0] rd_addr = '0;
  logic          rd_data_valid;
  logic [DW-1:0] rd_data;
  logic          mem_cen, mem_wen;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic [2:0]    fifo_level;
  logic          force_active;

  logic [DW-1:0]    bank [0:(1<<AW)-1];
  logic [AW+DW-1:0] wr_log [$];

  int n_cmp = 0;
  int n_err = 0;

  bank_port_arbiter #(.AW(AW), .DW(DW), .FIFO_DEPTH(4), .MAX_WAIT(8)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .spi_wr_valid(spi_wr_valid), .spi_wr_ready(spi_wr_ready),
    .spi_wr_addr(spi_wr_addr), .spi_wr_data(spi_wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr),
    .rd_data_valid(rd_data_valid), .rd_data(rd_data),
    .mem_cen(mem_cen), .mem_wen(mem_wen), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .fifo_level(fifo_level), .force_active(force_active)
  );

  always #5 clk = ~clk;

  // Behavioural SRAM: writes land at the edge, reads return one cycle later.
  always @(posedge clk) begin
    if (mem_cen) begin
      if (mem_wen) begin
        bank[mem_addr] <= mem_wdata;
        wr_log.push_back({mem_addr, mem_wdata});
      end else begin
        mem_rdata <= bank[mem_addr];
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_set(input logic [AW-1:0] a, input logic [DW-1:0] d);
    spi_wr_valid = 1'b1;
    spi_wr_addr  = a;
    spi_wr_data  = d;
  endtask

  initial begin
    int n_log;
    int f_cnt;
    int k;

    for (int i = 0; i < 10; i++) bank[i] = DW'(32'h100 + i);

    // ---------------- reset ----------------
    rd_valid = 1'b1;
    spi_wr_valid = 1'b1;
    tick();
    tick();
    check("rst_rd_ready",      64'(rd_ready),      64'(0));
    check("rst_mem_cen",       64'(mem_cen),       64'(0));
    check("rst_spi_wr_ready",  64'(spi_wr_ready),  64'(0));
    check("rst_fifo_level",    64'(fifo_level),    64'(0));
    check("rst_rd_data_valid", 64'(rd_data_valid), 64'(0));
    check("rst_force_active",  64'(force_active),  64'(0));
    rd_valid = 1'b0;
    spi_wr_valid = 1'b0;
    rst_n = 1'b1;
    #1;
    check("rel_spi_wr_ready", 64'(spi_wr_ready), 64'(1));
    check("rel_rd_ready",     64'(rd_ready),     64'(1));

    // ---------------- reads only ----------------
    for (int i = 0; i < 10; i++) begin
      tick();
      rd_valid = 1'b1;
      rd_addr  = AW'(i);
      #1;
      check("rd_ready",    64'(rd_ready), 64'(1));
      check("rd_mem_cen",  64'(mem_cen),  64'(1));
      check("rd_mem_wen",  64'(mem_wen),  64'(0));
      check("rd_mem_addr", 64'(mem_addr), 64'(i));
      if (i > 0) begin
        check("rd_data_valid", 64'(rd_data_valid), 64'(1));
        check("rd_data",       64'(rd_data),       64'(32'h100 + i - 1));
      end
    end
    tick();
    rd_valid = 1'b0;
    #1;
    check("rd_last_valid", 64'(rd_data_valid), 64'(1));
    check("rd_last_data",  64'(rd_data),       64'(32'h109));
    check("rd_idle_cen",   64'(mem_cen),       64'(0));
    tick();
    check("rd_valid_drop", 64'(rd_data_valid), 64'(0));
    check("rd_no_writes",  64'(wr_log.size()), 64'(0));

    // ---------------- writes only ----------------
    tick();
    push_set(12'h010, 32'hA);
    #1;
    check("wr_ready",       64'(spi_wr_ready), 64'(1));
    check("wr_no_bypass",   64'(mem_cen),      64'(0));
    tick();
    push_set(12'h011, 32'hB);
    #1;
    check("wr1_level",      64'(fifo_level),   64'(1));
    check("wr1_wen",        64'(mem_wen),      64'(1));
    check("wr1_addr",       64'(mem_addr),     64'(12'h010));
    check("wr1_data",       64'(mem_wdata),    64'(32'hA));
    tick();
    push_set(12'h012, 32'hC);
    #1;
    check("wr2_level",      64'(fifo_level),   64'(1));
    check("wr2_addr",       64'(mem_addr),     64'(12'h011));
    check("wr2_data",       64'(mem_wdata),    64'(32'hB));
    tick();
    spi_wr_valid = 1'b0;
    #1;
    check("wr3_level",      64'(fifo_level),   64'(1));
    check("wr3_wen",        64'(mem_wen),      64'(1));
    check("wr3_addr",       64'(mem_addr),     64'(12'h012));
    check("wr3_data",       64'(mem_wdata),    64'(32'hC));
    tick();
    check("wr_final_level", 64'(fifo_level),   64'(0));
    check("wr_idle_cen",    64'(mem_cen),      64'(0));
    check("wr_addr_hold",   64'(mem_addr),     64'(12'h012));
    check("wr_log_size",    64'(wr_log.size()), 64'(3));
    check("wr_log_first",   64'(wr_log[0]),    64'({12'h010, 32'hA}));
    check("wr_bank_011",    64'(bank[12'h011]), 64'(32'hB));

    // ---------------- starvation ----------------
    tick();
    rd_valid = 1'b1;
    rd_addr  = 12'h020;
    push_set(12'h030, 32'hDEAD);
    #1;
    check("stv_push_rd_ready", 64'(rd_ready), 64'(1));
    for (int c = 0; c < 8; c++) begin
      tick();
      spi_wr_valid = 1'b0;
      #1;
      check("stv_rd_ready", 64'(rd_ready),     64'(1));
      check("stv_no_wen",   64'(mem_wen),      64'(0));
      check("stv_no_force", 64'(force_active), 64'(0));
    end
    tick();
    check("stv_force",       64'(force_active),  64'(1));
    check("stv_rd_blocked",  64'(rd_ready),      64'(0));
    check("stv_wen",         64'(mem_wen),       64'(1));
    check("stv_addr",        64'(mem_addr),      64'(12'h030));
    check("stv_data",        64'(mem_wdata),     64'(32'hDEAD));
    tick();
    check("stv_force_end",   64'(force_active),  64'(0));
    check("stv_rd_resume",   64'(rd_ready),      64'(1));
    check("stv_level",       64'(fifo_level),    64'(0));
    check("stv_no_rd_valid", 64'(rd_data_valid), 64'(0));
    rd_valid = 1'b0;

    // ---------------- backpressure ----------------
    wr_log.delete();
    for (int i = 0; i < 4; i++) begin
      tick();
      rd_valid = 1'b1;
      rd_addr  = '0;
      push_set(AW'(12'h040 + i), DW'(32'h4000 + i));
      #1;
      check("bp_accept", 64'(spi_wr_ready), 64'(1));
    end
    tick();
    push_set(12'h044, 32'h4004);
    #1;
    check("bp_full_ready", 64'(spi_wr_ready), 64'(0));
    check("bp_full_level", 64'(fifo_level),   64'(4));
    for (int c = 0; c < 4; c++) begin
      tick();
      check("bp_wait_ready", 64'(spi_wr_ready), 64'(0));
      check("bp_wait_force", 64'(force_active), 64'(0));
    end
    tick();
    check("bp_force",         64'(force_active), 64'(1));
    check("bp_force_ready",   64'(spi_wr_ready), 64'(0));
    check("bp_force_addr",    64'(mem_addr),     64'(12'h040));
    tick();
    check("bp_ready_again",   64'(spi_wr_ready), 64'(1));
    check("bp_level_3",       64'(fifo_level),   64'(3));
    tick();
    spi_wr_valid = 1'b0;
    #1;
    check("bp_level_4",       64'(fifo_level),   64'(4));
    k = 0;
    while (fifo_level != 0 && k < 60) begin
      tick();
      k++;
    end
    check("bp_drained",  64'(fifo_level),     64'(0));
    check("bp_log_size", 64'(wr_log.size()),  64'(5));
    for (int i = 0; i < 5; i++) begin
      check("bp_order", 64'(wr_log[i]), 64'({AW'(12'h040 + i), DW'(32'h4000 + i)}));
      check("bp_bank",  64'(bank[12'h040 + i]), 64'(32'h4000 + i));
    end
    rd_valid = 1'b0;

    // ---------------- flush ----------------
    tick();
    rd_valid = 1'b1;
    push_set(12'h050, 32'h5000);
    tick();
    push_set(12'h051, 32'h5001);
    tick();
    push_set(12'h052, 32'h5002);
    #1;
    check("fl_level_2", 64'(fifo_level), 64'(2));
    tick();
    push_set(12'h053, 32'h5003);
    flush = 1'b1;
    #1;
    check("fl_level_3", 64'(fifo_level),   64'(3));
    check("fl_ready",   64'(spi_wr_ready), 64'(1));
    tick();
    flush = 1'b0;
    spi_wr_valid = 1'b0;
    #1;
    check("fl_cleared",  64'(fifo_level), 64'(0));
    check("fl_rd_ready", 64'(rd_ready),   64'(1));
    check("fl_no_wen",   64'(mem_wen),    64'(0));
    n_log = wr_log.size();
    f_cnt = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      f_cnt += int'(force_active);
    end
    check("fl_never_force", 64'(f_cnt),          64'(0));
    check("fl_no_writes",   64'(wr_log.size()),  64'(n_log));
    check("fl_level_end",   64'(fifo_level),     64'(0));
    rd_valid = 1'b0;

    // ---------------- reset mid-operation ----------------
    tick();
    rd_valid = 1'b1;
    rd_addr  = 12'h003;
    push_set(12'h060, 32'h6000);
    tick();
    push_set(12'h061, 32'h6001);
    tick();
    spi_wr_valid = 1'b0;
    #1;
    check("mr_level_2", 64'(fifo_level), 64'(2));
    tick();
    check("mr_rd_valid_pre", 64'(rd_data_valid), 64'(1));
    check("mr_rd_data_pre",  64'(rd_data),       64'(32'h103));
    n_log = wr_log.size();
    rst_n = 1'b0;
    #1;
    check("mr_rd_valid",  64'(rd_data_valid), 64'(0));
    check("mr_mem_cen",   64'(mem_cen),       64'(0));
    check("mr_level",     64'(fifo_level),    64'(0));
    check("mr_rd_ready",  64'(rd_ready),      64'(0));
    check("mr_wr_ready",  64'(spi_wr_ready),  64'(0));
    tick();
    tick();
    rd_valid = 1'b0;
    rst_n = 1'b1;
    #1;
    check("mr_rel_wr_ready", 64'(spi_wr_ready), 64'(1));
    check("mr_rel_rd_ready", 64'(rd_ready),     64'(1));
    for (int c = 0; c < 5; c++) tick();
    check("mr_idle_cen",  64'(mem_cen),        64'(0));
    check("mr_no_stale",  64'(wr_log.size()),  64'(n_log));
    check("mr_level_end", 64'(fifo_level),     64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
